instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Front-end stage of the single-cycle datapath. Owns the program counter and fetches instructions from instruction memory over a req/ack handshake.
- Presents each fetched instruction, with its PC, to decode and the immediate extender through a valid/ready handshake.
- Takes back the sign-extended immediate and a redirect flag to form the next PC (PC+4 or PC+ImmExt).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Must be a multiple of 4.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/pc/pc_plus4 hold a valid instruction.
- instr_ready  in  1  decode/extend accepts the instruction this cycle.
- instr  out  32  held instruction word. Bits [31:7] feed the extender's A input.
- pc  out  XLEN  address of the current instruction.
- pc_plus4  out  XLEN  pc + 4, mod 2^32.
- redirect  in  1  taken branch/jump; sampled only on the accept cycle.
- imm_ext  in  XLEN  sign-extended immediate from the extender (Q output).
- err_misaligned  out  1  sticky misaligned-target flag.

Behaviour:
- The FSM has four states: IDLE, FETCH, ISSUE, HALT. State, pc, instr and err_misaligned are registers.
- Reset (synchronous, active-high, wins over everything, including mid-fetch or mid-issue) sets:
  - state = IDLE, pc = RESET_PC, instr = 32'h0000_0013 (NOP), err_misaligned = 0.
  - Hence imem_req = 0 and instr_valid = 0.
  - Any imem_ack arriving during or after reset while in IDLE is ignored.
- Outputs decoded from state:
  - imem_req = 1 only in FETCH; imem_addr = pc at all times.
  - instr_valid = 1 only in ISSUE.
  - pc_plus4 is combinational from pc.
- IDLE -> FETCH unconditionally on the next edge. The first request appears one cycle after reset deasserts.
- FETCH:
  - imem_req is held high and imem_addr stable until imem_ack.
  - On a cycle with imem_ack = 1: instr <= imem_rdata, state -> ISSUE.
  - No timeout; the block waits indefinitely.
- ISSUE:
  - instr, pc and pc_plus4 are held stable while instr_ready = 0.
  - Accept = instr_valid && instr_ready. On accept: target = redirect ? (pc + imm_ext) : (pc + 4), 32-bit two's-complement add, carry discarded (wrap-around).
  - If redirect = 1 and target[1:0] != 0: pc unchanged, err_misaligned <= 1, state -> HALT.
  - Otherwise: pc <= target, state -> FETCH.
- HALT: imem_req = 0, instr_valid = 0. Only reset exits.
- redirect and imm_ext are don't-care outside the accept cycle.
- imem_ack outside FETCH is ignored.
- Timing: minimum 2 cycles per instruction (1 FETCH with immediate ack + 1 ISSUE with immediate ready). Fetch latency is 1 + memory wait cycles.
- pc+4 cannot be misaligned because RESET_PC is aligned, so only redirects are checked.

Test Plan:
- Reset then immediate ack/ready, imem_rdata = 0x00500093, redirect = 0:
  - During reset: imem_req = 0, instr_valid = 0, pc = 0x00000000, instr = 0x00000013.
  - First request one cycle after reset drops, imem_addr = 0x0.
  - Issue cycle: instr = 0x00500093, pc_plus4 = 0x4.
  - Next fetch at imem_addr = 0x4.
- Memory wait: ack delayed 3 cycles at pc 0x8 -> imem_req high and imem_addr = 0x8 for 4 cycles, then instr_valid for one cycle.
- Backpressure: instr_ready low for 5 cycles in ISSUE with instr = 0xFE0008E3 -> instr, pc and instr_valid stay constant; no new imem_req until accept.
- Redirect: pc = 0x100, imm_ext = 0xFFFFFFF0, redirect = 1 on accept -> next imem_addr = 0x000000F0.
- Wrap-around: RESET_PC = 0xFFFFFFFC, redirect = 0 -> next imem_addr = 0x00000000.
- Misaligned redirect: pc = 0x20, imm_ext = 0x00000002 -> err_misaligned = 1, state HALT, pc = 0x20.
  - imem_req stays 0 for 10 cycles.
  - Reset clears err_misaligned and restarts at RESET_PC.
  - A reset asserted mid-FETCH with ack pending returns to IDLE with pc = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack side, decode valid/ready side,
// and the redirect/immediate return path from the extender.
interface instr_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            redirect;
    logic [XLEN-1:0] imm_ext;
    logic            err_misaligned;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, err_misaligned,
        input  imem_ack, imem_rdata, instr_ready, redirect, imm_ext
    );

    // Memory / decode / extender side
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, err_misaligned,
        output imem_ack, imem_rdata, instr_ready, redirect, imm_ext
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, issues over valid/ready,
// and forms the next PC from pc+4 or pc+imm_ext, halting on a misaligned redirect.
module instr_fetch #(
    parameter int unsigned            XLEN     = 32,
    parameter logic        [XLEN-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    instr_fetch_if.master bus
);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            err_q;
    logic            req_q;
    logic            valid_q;
    logic [XLEN-1:0] target;

    assign target = bus.redirect ? (pc_q + bus.imm_ext) : (pc_q + PC_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        state_q <= StIssue;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        // pc+4 stays aligned, so only a redirect target can trap
                        if (bus.redirect && (target[1:0] != 2'b00)) begin
                            err_q   <= 1'b1;
                            state_q <= StHalt;
                        end else begin
                            pc_q    <= target;
                            state_q <= StFetch;
                            req_q   <= 1'b1;
                        end
                    end
                end
                StHalt: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req       = req_q;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = valid_q;
    assign bus.instr          = instr_q;
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_q + PC_STEP;
    assign bus.err_misaligned = err_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch/issue flow, memory wait, backpressure,
// redirect, wrap-around, misaligned-redirect halt and reset recovery.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.XLEN(32)) bus_a ();
    instr_fetch_if #(.XLEN(32)) bus_b ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.master)
    );

    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.imem_ack    = 1'b1;
        bus_a.imem_rdata  = 32'h0050_0093;
        bus_a.instr_ready = 1'b0;
        bus_a.redirect    = 1'b0;
        bus_a.imm_ext     = '0;
        bus_b.imem_ack    = 1'b1;
        bus_b.imem_rdata  = 32'h0000_0013;
        bus_b.instr_ready = 1'b1;
        bus_b.redirect    = 1'b0;
        bus_b.imm_ext     = '0;

        // Reset with ack already high: must be ignored
        step();
        step();
        chk("rst_req", {31'b0, bus_a.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus_a.instr_valid}, 32'd0);
        chk("rst_pc", bus_a.pc, 32'h0);
        chk("rst_instr", bus_a.instr, 32'h0000_0013);
        chk("rst_err", {31'b0, bus_a.err_misaligned}, 32'd0);

        reset_a = 1'b0;
        bus_a.instr_ready = 1'b1;
        step();
        chk("first_req", {31'b0, bus_a.imem_req}, 32'd1);
        chk("first_addr", bus_a.imem_addr, 32'h0);
        chk("first_valid", {31'b0, bus_a.instr_valid}, 32'd0);

        step();
        chk("issue0_valid", {31'b0, bus_a.instr_valid}, 32'd1);
        chk("issue0_instr", bus_a.instr, 32'h0050_0093);
        chk("issue0_pc4", bus_a.pc_plus4, 32'h4);
        chk("issue0_req", {31'b0, bus_a.imem_req}, 32'd0);

        step();
        chk("fetch4_req", {31'b0, bus_a.imem_req}, 32'd1);
        chk("fetch4_addr", bus_a.imem_addr, 32'h4);

        step();
        chk("issue4_pc", bus_a.pc, 32'h4);
        step();
        chk("fetch8_req", {31'b0, bus_a.imem_req}, 32'd1);
        chk("fetch8_addr", bus_a.imem_addr, 32'h8);

        // Memory wait: ack held off for 3 cycles
        bus_a.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", {31'b0, bus_a.imem_req}, 32'd1);
            chk("wait_addr", bus_a.imem_addr, 32'h8);
            chk("wait_valid", {31'b0, bus_a.instr_valid}, 32'd0);
        end
        bus_a.imem_ack    = 1'b1;
        bus_a.imem_rdata  = 32'hFE00_08E3;
        bus_a.instr_ready = 1'b0;
        step();

        // Backpressure; a stray ack with new data must not disturb the held word
        bus_a.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, bus_a.instr_valid}, 32'd1);
            chk("bp_instr", bus_a.instr, 32'hFE00_08E3);
            chk("bp_pc", bus_a.pc, 32'h8);
            chk("bp_req", {31'b0, bus_a.imem_req}, 32'd0);
            step();
        end
        chk("bp_end_valid", {31'b0, bus_a.instr_valid}, 32'd1);
        chk("bp_end_instr", bus_a.instr, 32'hFE00_08E3);
        bus_a.instr_ready = 1'b1;
        step();
        chk("post_bp_addr", bus_a.imem_addr, 32'hC);
        chk("post_bp_req", {31'b0, bus_a.imem_req}, 32'd1);

        // Redirect 0xC + 0xF4 -> 0x100, then 0x100 + (-16) -> 0xF0
        step();
        bus_a.redirect = 1'b1;
        bus_a.imm_ext  = 32'h0000_00F4;
        step();
        chk("redir100_addr", bus_a.imem_addr, 32'h100);
        bus_a.redirect = 1'b0;
        step();
        chk("issue100_pc", bus_a.pc, 32'h100);
        chk("issue100_pc4", bus_a.pc_plus4, 32'h104);
        bus_a.redirect = 1'b1;
        bus_a.imm_ext  = 32'hFFFF_FFF0;
        step();
        chk("redir_f0_addr", bus_a.imem_addr, 32'hF0);
        chk("redir_f0_err", {31'b0, bus_a.err_misaligned}, 32'd0);

        // 0xF0 + 0xFFFFFF30 -> 0x20
        bus_a.imm_ext = 32'hFFFF_FF30;
        step();
        step();
        chk("redir20_addr", bus_a.imem_addr, 32'h20);
        bus_a.redirect = 1'b0;
        step();
        chk("issue20_pc", bus_a.pc, 32'h20);

        // Misaligned redirect 0x20 + 2
        bus_a.redirect = 1'b1;
        bus_a.imm_ext  = 32'h0000_0002;
        step();
        chk("mis_err", {31'b0, bus_a.err_misaligned}, 32'd1);
        chk("mis_pc", bus_a.pc, 32'h20);
        chk("mis_req", {31'b0, bus_a.imem_req}, 32'd0);
        chk("mis_valid", {31'b0, bus_a.instr_valid}, 32'd0);
        bus_a.redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_req", {31'b0, bus_a.imem_req}, 32'd0);
            chk("halt_err", {31'b0, bus_a.err_misaligned}, 32'd1);
        end

        // Reset leaves HALT
        reset_a = 1'b1;
        step();
        chk("halt_rst_err", {31'b0, bus_a.err_misaligned}, 32'd0);
        chk("halt_rst_pc", bus_a.pc, 32'h0);
        reset_a = 1'b0;
        step();
        chk("restart_req", {31'b0, bus_a.imem_req}, 32'd1);
        chk("restart_addr", bus_a.imem_addr, 32'h0);
        step();
        step();
        bus_a.imem_ack = 1'b0;
        step();
        chk("midfetch_addr", bus_a.imem_addr, 32'h4);
        chk("midfetch_req", {31'b0, bus_a.imem_req}, 32'd1);

        // Reset mid-fetch while the ack arrives
        reset_a = 1'b1;
        bus_a.imem_ack = 1'b1;
        step();
        chk("midrst_pc", bus_a.pc, 32'h0);
        chk("midrst_req", {31'b0, bus_a.imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, bus_a.instr_valid}, 32'd0);
        chk("midrst_instr", bus_a.instr, 32'h0000_0013);
        reset_a = 1'b0;
        step();
        chk("midrst_restart", bus_a.imem_addr, 32'h0);

        // Wrap-around from RESET_PC = 0xFFFFFFFC
        reset_b = 1'b0;
        step();
        chk("wrap_first_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc4", bus_b.pc_plus4, 32'h0);
        step();
        chk("wrap_next_addr", bus_b.imem_addr, 32'h0);
        chk("wrap_next_req", {31'b0, bus_b.imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
